// File: rtl/ysyx_23060061_mem_arbiter_if.sv
// Shared memory bus between the IFU/LSU masters, the arbiter and the memory.
// "slave" is the arbiter's view; "master" is the view of everything around it.
interface ysyx_23060061_mem_arbiter_if;
    logic        m0_req_valid;
    logic        m0_req_ready;
    logic [31:0] m0_addr;
    logic        m0_resp_valid;
    logic        m0_resp_ready;

    logic        m1_req_valid;
    logic        m1_req_ready;
    logic        m1_wen;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wmask;
    logic        m1_resp_valid;
    logic        m1_resp_ready;

    logic [31:0] rdata;

    logic        s_req_valid;
    logic        s_req_ready;
    logic        s_wen;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wmask;
    logic [31:0] s_rdata;
    logic        s_resp_valid;
    logic        s_resp_ready;

    modport slave (
        input  m0_req_valid, m0_addr, m0_resp_ready,
        input  m1_req_valid, m1_wen, m1_addr, m1_wdata, m1_wmask, m1_resp_ready,
        input  s_req_ready, s_rdata, s_resp_valid,
        output m0_req_ready, m0_resp_valid,
        output m1_req_ready, m1_resp_valid,
        output rdata,
        output s_req_valid, s_wen, s_addr, s_wdata, s_wmask, s_resp_ready
    );

    modport master (
        output m0_req_valid, m0_addr, m0_resp_ready,
        output m1_req_valid, m1_wen, m1_addr, m1_wdata, m1_wmask, m1_resp_ready,
        output s_req_ready, s_rdata, s_resp_valid,
        input  m0_req_ready, m0_resp_valid,
        input  m1_req_ready, m1_resp_valid,
        input  rdata,
        input  s_req_valid, s_wen, s_addr, s_wdata, s_wmask, s_resp_ready
    );
endinterface

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-master (IFU = m0, LSU = m1) single-outstanding memory arbiter.
// state   | meaning
// IDLE    | arbitrate, accept one master request
// REQ     | present latched request to memory until accepted
// RESP    | forward memory response to the granted master
module ysyx_23060061_mem_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_23060061_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;

    logic w_idle;
    logic w_req;
    logic w_resp;
    logic w_pick_m1;
    logic w_acc_m0;
    logic w_acc_m1;
    logic w_resp_ready;
    logic w_resp_fire;

    // rst gates the accept path so no ready leaks out while reset is held
    assign w_idle = (r_state == ST_IDLE) && !rst;
    assign w_req  = (r_state == ST_REQ);
    assign w_resp = (r_state == ST_RESP);

    always_comb begin
        w_pick_m1 = 1'b0;
        if (bus.m1_req_valid && !bus.m0_req_valid) begin
            w_pick_m1 = 1'b1;
        end else if (bus.m1_req_valid && bus.m0_req_valid) begin
            w_pick_m1 = (RR_EN != 0) ? !r_last_grant : 1'b1;
        end
    end

    assign w_acc_m0     = w_idle && bus.m0_req_valid && !w_pick_m1;
    assign w_acc_m1     = w_idle && bus.m1_req_valid && w_pick_m1;
    assign w_resp_ready = w_resp && (r_grant ? bus.m1_resp_ready : bus.m0_resp_ready);
    assign w_resp_fire  = w_resp_ready && bus.s_resp_valid;

    assign bus.m0_req_ready  = w_acc_m0;
    assign bus.m1_req_ready  = w_acc_m1;
    assign bus.m0_resp_valid = w_resp && bus.s_resp_valid && !r_grant;
    assign bus.m1_resp_valid = w_resp && bus.s_resp_valid && r_grant;
    assign bus.rdata         = bus.s_rdata;
    assign bus.s_req_valid   = w_req;
    assign bus.s_resp_ready  = w_resp_ready;
    assign bus.s_wen         = r_wen;
    assign bus.s_addr        = r_addr;
    assign bus.s_wdata       = r_wdata;
    assign bus.s_wmask       = r_wmask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wen        <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_wmask      <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_m0) begin
                        r_grant <= 1'b0;
                        r_wen   <= 1'b0;
                        r_addr  <= bus.m0_addr;
                        r_wdata <= 32'd0;
                        r_wmask <= 4'd0;
                        r_state <= ST_REQ;
                    end else if (w_acc_m1) begin
                        r_grant <= 1'b1;
                        r_wen   <= bus.m1_wen;
                        r_addr  <= bus.m1_addr;
                        r_wdata <= bus.m1_wdata;
                        r_wmask <= bus.m1_wmask;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.s_req_ready) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_resp_fire) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
